arm_dmem_responder: RTL and testbench
=====================================

# arm_dmem_responder

Data-memory responder that sits on the memory side of the pipeline's MEM stage. It accepts load/store requests: byte address, 4-bit byte-lane write enables and store data. It performs the access on an internal byte-writable word array after a configurable number of wait states and returns the raw, unrotated 32-bit word on `mem_data_out`. While an access is in flight it asserts `mem_stall` to freeze the pipeline; byte extraction on loads remains the MEM stage's job.

## Interface

Parameters:
- `MEM_WORDS`, 1024 — number of 32-bit words in the array; index = `req_addr[31:2]`.
- `WAIT_STATES`, 1 — cycles spent in BUSY before the access completes; legal range 0–15.

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `rst_b`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — MEM stage presents a request.
- `req_addr`  in  32  — byte address.
- `req_write_en`  in  4  — byte-lane write enables; 4'b0000 = read.
- `req_store_data`  in  32  — store data, unaligned (byte stores in [7:0]).
- `req_ready`  out  1  — responder can accept a request this cycle.
- `mem_stall`  out  1  — pipeline must hold EX/MEM.
- `rsp_valid`  out  1  — one-cycle pulse: access complete.
- `rsp_err`  out  1  — valid with `rsp_valid`: access faulted.
- `mem_data_out`  out  32  — last word read; raw lane order.

## Operation

FSM states are IDLE, BUSY and DONE.
- **IDLE:** `req_ready`=1. On `req_valid`, capture addr/wen/data and load wait counter = `WAIT_STATES`. Next state is BUSY if `WAIT_STATES`>0, otherwise DONE.
- **BUSY:** decrement the counter each cycle. When it reaches 1, go to DONE. `req_ready`=0.
- **DONE:** perform the array access. Pulse `rsp_valid`, drive `rsp_err`, return to IDLE. `req_ready`=0.

Store alignment:
- Write word = `req_store_data` rotated left by 8×`addr[1:0]`.
- Only lanes with `wen[i]`=1 are written; other lanes are unchanged.

Reads:
- `mem_data_out` ← array[index] registered in DONE.
- It holds its value until the next completed read.
- Writes never change `mem_data_out`.

Errors (`rsp_err`=1, no array write, `mem_data_out` ← 32'h0 for reads):
- index ≥ `MEM_WORDS`.
- `wen`=4'b1111 with `addr[1:0]`≠0.
- `wen` not one of 0000, 0001/0010/0100/1000, 0011/1100, 1111.

`mem_stall` = (IDLE ∧ `req_valid`) ∨ BUSY. It is low in DONE, so the pipeline advances on the edge that ends DONE.

## Timing

- **Reset values:** state IDLE, `req_ready`=1, `mem_stall`=0, `rsp_valid`=0, `rsp_err`=0, `mem_data_out`=32'h0, counter 0.
- **Latency:**
  - Request accepted at edge N; `rsp_valid` and the read data are visible in cycle N+`WAIT_STATES`+1.
  - With `WAIT_STATES`=0 the response appears in the cycle after acceptance.
- **Back-to-back:** the earliest next acceptance is the cycle after DONE. Peak throughput is one access per `WAIT_STATES`+2 cycles.
- **Request hold:** `req_valid` and request fields are ignored while `req_ready`=0. The requester holds them under `mem_stall`, and they are re-sampled only in IDLE.
- **Reset mid-operation:**
  - State returns to IDLE immediately and the pending access is dropped (no write, no `rsp_valid`).
  - Array contents are not reset.

## Configuration

`ARM_DMEM_POSTED_WRITE_EN`:
- **Defined:**
  - A write accepted in IDLE does not assert `mem_stall`; the pipeline continues while the write completes in BUSY/DONE.
  - A new request arriving while a posted write is in BUSY/DONE asserts `mem_stall` until IDLE.
  - Read behaviour is unchanged.
  - The `rsp_err` of a posted write still pulses with `rsp_valid`.
- **Undefined:** writes stall exactly as reads do (`mem_stall` formula above).

## Test plan

- **Aligned word write then read:** `WAIT_STATES`=1; write 0xDEADBEEF @0x10, wen=1111, then read @0x10.
  - Each access gives `rsp_valid` 2 cycles after acceptance.
  - `mem_data_out`=0xDEADBEEF; `mem_stall` is high for exactly 2 cycles per access.
- **Byte store into lane 2:** with 0xDEADBEEF @0x10, store data 0x000000A5 @0x12, wen=0100; read @0x10 → 0xDEA5BEEF.
- **Errors:**
  - Word store @0x11 → `rsp_err`=1 and the word is unchanged.
  - Read @ byte 4×`MEM_WORDS` → `rsp_err`=1, `mem_data_out`=0.
- **Request while busy:** `WAIT_STATES`=3; a second `req_valid` with different data during BUSY is not captured. It is accepted only after DONE, and both responses arrive in order.
- **Reset mid-operation:** assert `rst_b`=0 in BUSY of a write of 0x12345678 @0x20.
  - Outputs go to reset values asynchronously.
  - A subsequent read @0x20 returns the old contents.
- **Posted write (macro defined):** a write @0x30 gives `mem_stall`=0 in the accept cycle. A read @0x30 issued the next cycle stalls until IDLE, then returns the new data.

Source files
------------

// File: rtl/arm_dmem_responder.sv
// Data-memory responder: byte-writable word array behind an IDLE/BUSY/DONE wait-state FSM.
// Optional macro ARM_DMEM_POSTED_WRITE_EN lets writes complete without stalling the pipeline.
module arm_dmem_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_write_en,
    input  logic [31:0] req_store_data,
    output logic        req_ready,
    output logic        mem_stall,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] mem_data_out
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

`ifdef ARM_DMEM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_stall;

    logic [31:0] r_addr;
    logic [3:0]  r_wen;
    logic [31:0] r_data;
    logic [3:0]  r_cnt;

    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_data_out;

    logic [31:0] r_mem [MEM_WORDS];

    logic [31:0]      w_acc_addr;
    logic [3:0]       w_acc_wen;
    logic [31:0]      w_acc_data;
    logic [31:0]      w_wdata;
    logic [IDX_W-1:0] w_idx;
    logic             w_oob;
    logic             w_wen_ok;
    logic             w_misalign;
    logic             w_err;
    logic             w_done_nxt;
    logic             w_mem_we;
    logic             w_wr_inflight;

    assign w_wr_inflight = (r_wen != 4'b0000);

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and stall; a posted write only stalls a newcomer queued behind it
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = req_valid && !(POSTED && (req_write_en != 4'b0000));
                if (req_valid) w_state_nxt = (WS == 4'd0) ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                w_stall = (POSTED && w_wr_inflight) ? req_valid : 1'b1;
                if (r_cnt <= 4'd1) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_stall     = POSTED && w_wr_inflight && req_valid;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign req_ready    = (r_state == S_IDLE);
    assign mem_stall    = w_stall & rst_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_err;
    assign mem_data_out = r_data_out;

    // With zero wait states the access happens on the accept edge, so use the live request
    assign w_acc_addr = (r_state == S_IDLE) ? req_addr       : r_addr;
    assign w_acc_wen  = (r_state == S_IDLE) ? req_write_en   : r_wen;
    assign w_acc_data = (r_state == S_IDLE) ? req_store_data : r_data;
    assign w_idx      = w_acc_addr[IDX_W+1:2];

    always_comb begin
        w_wdata = w_acc_data;
        case (w_acc_addr[1:0])
            2'd0:    w_wdata = w_acc_data;
            2'd1:    w_wdata = {w_acc_data[23:0], w_acc_data[31:24]};
            2'd2:    w_wdata = {w_acc_data[15:0], w_acc_data[31:16]};
            default: w_wdata = {w_acc_data[7:0],  w_acc_data[31:8]};
        endcase
    end

    always_comb begin
        w_wen_ok = 1'b0;
        case (w_acc_wen)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_wen_ok = 1'b1;
            default:                   w_wen_ok = 1'b0;
        endcase
    end

    assign w_oob      = ({2'b00, w_acc_addr[31:2]} >= MEM_WORDS);
    assign w_misalign = (w_acc_wen == 4'b1111) && (w_acc_addr[1:0] != 2'b00);
    assign w_err      = w_oob || !w_wen_ok || w_misalign;
    assign w_done_nxt = (w_state_nxt == S_DONE);
    assign w_mem_we   = w_done_nxt && !w_err && (w_acc_wen != 4'b0000);

    // Request capture and wait counter
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_addr <= 32'h0;
            r_wen  <= 4'h0;
            r_data <= 32'h0;
            r_cnt  <= 4'h0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_addr <= req_addr;
            r_wen  <= req_write_en;
            r_data <= req_store_data;
            r_cnt  <= WS;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response registers update on the edge entering DONE so they are visible during DONE
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_data_out  <= 32'h0;
        end else begin
            r_rsp_valid <= w_done_nxt;
            r_rsp_err   <= w_done_nxt && w_err;
            if (w_done_nxt && (w_acc_wen == 4'b0000)) begin
                r_data_out <= w_err ? 32'h0 : r_mem[w_idx];
            end
        end
    end

    // Storage array is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_wen[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_arm_dmem_responder.sv
// Directed bench for arm_dmem_responder: a WAIT_STATES=1 instance and a WAIT_STATES=3 instance
// share request inputs; the idle one is held in reset while the other is exercised.
module tb_arm_dmem_responder;

`ifdef ARM_DMEM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst1_b, rst3_b;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_write_en;
    logic [31:0] req_store_data;

    logic        ready1, stall1, rspv1, err1;
    logic [31:0] dout1;
    logic        ready3, stall3, rspv3, err3;
    logic [31:0] dout3;

    bit          sel;
    logic        w_ready, w_stall, w_rspv, w_err;
    logic [31:0] w_dout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arm_dmem_responder #(.MEM_WORDS(1024), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst_b(rst1_b), .req_valid(req_valid), .req_addr(req_addr),
        .req_write_en(req_write_en), .req_store_data(req_store_data),
        .req_ready(ready1), .mem_stall(stall1), .rsp_valid(rspv1), .rsp_err(err1),
        .mem_data_out(dout1)
    );

    arm_dmem_responder #(.MEM_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_b(rst3_b), .req_valid(req_valid), .req_addr(req_addr),
        .req_write_en(req_write_en), .req_store_data(req_store_data),
        .req_ready(ready3), .mem_stall(stall3), .rsp_valid(rspv3), .rsp_err(err3),
        .mem_data_out(dout3)
    );

    always_comb begin
        w_ready = sel ? ready3 : ready1;
        w_stall = sel ? stall3 : stall1;
        w_rspv  = sel ? rspv3  : rspv1;
        w_err   = sel ? err3   : err1;
        w_dout  = sel ? dout3  : dout1;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] data;
        logic        err;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ready"}, 32'(w_ready), 32'd1);
        chk({tag, " stall"}, 32'(w_stall), 32'd0);
        chk({tag, " rsp_valid"}, 32'(w_rspv), 32'd0);
        chk({tag, " rsp_err"}, 32'(w_err), 32'd0);
        chk({tag, " data_out"}, w_dout, 32'h0);
    endtask

    // One request on the selected instance: latency, stall cycles, error, data, pulse width
    task automatic access(input string tag, input logic [31:0] addr, input logic [3:0] wen,
                          input logic [31:0] data, input logic exp_err, input logic [31:0] exp_dout);
        int lat = 0;
        int stalls;
        int exp_lat;
        bit seen = 1'b0;
        exp_lat = sel ? 4 : 2;
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_write_en = wen; req_store_data = data;
        #1;
        stalls = w_stall ? 1 : 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (w_stall) stalls++;
            if (w_rspv) begin
                seen = 1'b1;
                lat  = c;
                chk({tag, " rsp_err"}, 32'(w_err), 32'(exp_err));
                chk({tag, " data_out"}, w_dout, exp_dout);
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " stall cycles"}, 32'(stalls), (POSTED && wen != 4'b0000) ? 32'd0 : 32'(exp_lat));
        @(negedge clk);
        chk({tag, " pulse end"}, 32'(w_rspv), 32'd0);
        chk({tag, " ready after"}, 32'(w_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st_seen;
        logic [31:0] rs_seen;

        vecs[0]  = '{32'h10,   4'b1111, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{32'h10,   4'b0000, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{32'h12,   4'b0100, 32'h000000A5, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{32'h10,   4'b0000, 32'h0,        1'b0, 32'hDEA5BEEF};
        vecs[4]  = '{32'h11,   4'b1111, 32'h99999999, 1'b1, 32'hDEA5BEEF};
        vecs[5]  = '{32'h10,   4'b0000, 32'h0,        1'b0, 32'hDEA5BEEF};
        vecs[6]  = '{32'h1000, 4'b0000, 32'h0,        1'b1, 32'h0};
        vecs[7]  = '{32'h12,   4'b1100, 32'h0000CAFE, 1'b0, 32'h0};
        vecs[8]  = '{32'h10,   4'b0000, 32'h0,        1'b0, 32'hCAFEBEEF};
        vecs[9]  = '{32'h10,   4'b0101, 32'h11111111, 1'b1, 32'hCAFEBEEF};
        vecs[10] = '{32'h13,   4'b1000, 32'h00000077, 1'b0, 32'hCAFEBEEF};
        vecs[11] = '{32'h10,   4'b0000, 32'h0,        1'b0, 32'h77FEBEEF};
        vecs[12] = '{32'h10,   4'b0001, 32'h0000005A, 1'b0, 32'h77FEBEEF};
        vecs[13] = '{32'h10,   4'b0000, 32'h0,        1'b0, 32'h77FEBE5A};
        vecs[14] = '{32'hFFC,  4'b1111, 32'h01234567, 1'b0, 32'h77FEBE5A};
        vecs[15] = '{32'hFFC,  4'b0000, 32'h0,        1'b0, 32'h01234567};
        vecs[16] = '{32'h1000, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h01234567};
        vecs[17] = '{32'h20,   4'b1111, 32'hAAAA5555, 1'b0, 32'h01234567};

        rst1_b = 1'b0; rst3_b = 1'b0; sel = 1'b0;
        req_valid = 1'b0; req_addr = 32'h0; req_write_en = 4'h0; req_store_data = 32'h0;
        repeat (3) @(negedge clk);
        sel = 1'b0; #1 chk_reset("reset dut1");
        sel = 1'b1; #1 chk_reset("reset dut3");
        sel = 1'b0;
        @(negedge clk) rst1_b = 1'b1;

        for (int i = 0; i < 18; i++) begin
            access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wen, vecs[i].data,
                   vecs[i].err, vecs[i].dout);
        end

        // Reset while a write of 0x12345678 @0x20 is in BUSY
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h20; req_write_en = 4'b1111; req_store_data = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("midrst busy stall", 32'(w_stall), 32'd1);
        rst1_b = 1'b0;
        #1 chk_reset("midrst async");
        @(posedge clk);
        @(negedge clk);
        chk("midrst no rsp", 32'(w_rspv), 32'd0);
        rst1_b = 1'b1;
        access("midrst readback", 32'h20, 4'b0000, 32'h0, 1'b0, 32'hAAAA5555);

`ifdef ARM_DMEM_POSTED_WRITE_EN
        // Posted write @0x30 followed by a read the next cycle
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h30; req_write_en = 4'b1111; req_store_data = 32'h0BADF00D;
        #1;
        st_seen = 32'h0; rs_seen = 32'h0;
        st_seen[0] = w_stall;
        @(posedge clk);
        #1 req_write_en = 4'b0000; req_store_data = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            st_seen[c] = w_stall;
            rs_seen[c] = w_rspv;
            if (c == 5) chk("posted read data", w_dout, 32'h0BADF00D);
            if (c == 3) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        chk("posted stall pattern", st_seen, 32'h1E);
        chk("posted rsp pattern", rs_seen, 32'h24);
`endif

        // WAIT_STATES=3: fields change during BUSY and must not be captured
        rst1_b = 1'b0;
        sel = 1'b1;
        @(negedge clk) rst3_b = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h40; req_write_en = 4'b1111; req_store_data = 32'h11112222;
        #1;
        st_seen = 32'h0; rs_seen = 32'h0;
        st_seen[0] = w_stall;
        @(posedge clk);
        #1 req_addr = 32'h44; req_store_data = 32'h33334444;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            st_seen[c] = w_stall;
            rs_seen[c] = w_rspv;
            if (w_rspv) chk($sformatf("busy rsp_err c%0d", c), 32'(w_err), 32'd0);
            if (c == 5) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        chk("busy stall pattern", st_seen, POSTED ? 32'h1E : 32'h1EF);
        chk("busy rsp pattern", rs_seen, 32'h210);
        access("busy rd40", 32'h40, 4'b0000, 32'h0, 1'b0, 32'h11112222);
        access("busy rd44", 32'h44, 4'b0000, 32'h0, 1'b0, 32'h33334444);
        access("ws3 oob read", 32'h1000, 4'b0000, 32'h0, 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
